// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: state encoding, default geometry, NOP and opcode constants.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int          MEM_WORDS_DEFAULT = 64;
  localparam logic [31:0] NOP               = 32'h0000_0000;
  localparam logic [5:0]  OP_J              = 6'h02;
  localparam logic [5:0]  OP_BEQ            = 6'h04;

  // A PC is unfetchable when past the end of memory or not word aligned.
  function automatic logic pc_fault(input logic [31:0] pc, input logic [31:0] limit);
    return (pc >= limit) || (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: jump beats branch beats sequential.
module next_pc_logic (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        self_jump
);

  logic [31:0] seq_s;
  logic [31:0] branch_tgt_s;
  logic [31:0] jump_tgt_s;

  assign seq_s        = pc + 32'd4;
  assign branch_tgt_s = seq_s + (branch_offset << 5'd2);
  assign jump_tgt_s   = {seq_s[31:28], jump_index, 2'b00};

  // Priority select of the next fetch address.
  always_comb begin
    next_pc = seq_s;
    if (jump) begin
      next_pc = jump_tgt_s;
    end else if (branch_taken) begin
      next_pc = branch_tgt_s;
    end else begin
      next_pc = seq_s;
    end
  end

  assign pc_plus4  = seq_s;
  assign self_jump = jump && (jump_tgt_s == pc);

endmodule

// File: rtl/fetch_unit.sv
// PC register and fetch-control FSM in front of instruction memory.
// Optional performance counters enabled by defining FETCH_PERF_EN.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic        halted,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic [31:0]  next_pc_s, pc_plus4_s;
  logic         self_jump_s, fault_s, valid_s;

  next_pc_logic u_next_pc (
    .pc            (pc_r),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .next_pc       (next_pc_s),
    .pc_plus4      (pc_plus4_s),
    .self_jump     (self_jump_s)
  );

  assign fault_s = pc_fault(pc_r, PC_LIMIT);

  // Next-state, next-PC and valid decode; a bad PC outranks stall.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    valid_s     = 1'b0;
    case (state_r)
      ST_BOOT: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (fault_s) begin
          state_nxt_s = ST_HALT;
        end else if (stall) begin
          state_nxt_s = ST_STALL;
        end else begin
          valid_s  = 1'b1;
          pc_nxt_s = next_pc_s;
          if (self_jump_s) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_STALL: begin
        if (stall) begin
          state_nxt_s = ST_STALL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_BOOT;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  assign address   = pc_r;
  assign pc_plus4  = pc_plus4_s;
  assign valid     = valid_s;
  assign instr_out = valid_s ? instruction : NOP;
  assign halted    = (state_r == ST_HALT);

`ifdef FETCH_PERF_EN
  logic [31:0] retired_r, stall_r;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= 32'h0;
      stall_r   <= 32'h0;
    end else begin
      if (valid_s) begin
        retired_r <= retired_r + 32'd1;
      end else begin
        retired_r <= retired_r;
      end
      if (state_r == ST_STALL) begin
        stall_r <= stall_r + 32'd1;
      end else begin
        stall_r <= stall_r;
      end
    end
  end

  assign retired_cnt = retired_r;
  assign stall_cnt   = stall_r;
`else
  assign retired_cnt = 32'h0;
  assign stall_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, random run vs model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] address, instruction, instr_out, pc_plus4, retired_cnt, stall_cnt;
  logic        valid, halted;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  always_comb instruction = mem[address[7:2]];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .address(address), .instruction(instruction), .instr_out(instr_out),
    .pc_plus4(pc_plus4), .valid(valid), .halted(halted),
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model: PC plus three independent mode flags
  logic [31:0] m_pc, m_ret, m_stc;
  bit          m_boot, m_stall, m_halt;

  typedef struct {
    logic        s;
    logic        br;
    logic [31:0] off;
    logic        j;
    logic [25:0] idx;
    logic [31:0] ea;
    logic        ev;
    logic        eh;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  function automatic bit m_fetch_ok();
    return !m_boot && !m_stall && !m_halt && (m_pc < 32'd256) && (m_pc[1:0] == 2'b00);
  endfunction

  task automatic drive(input logic s, input logic b, input logic [31:0] off,
                       input logic j, input logic [25:0] idx);
    stall = s; branch_taken = b; branch_offset = off; jump = j; jump_index = idx;
  endtask

  task automatic check_model();
    bit ev;
    ev = m_fetch_ok() && !stall;
    chk("address", address, m_pc);
    chk("valid", 32'(valid), 32'(ev));
    chk("instr_out", instr_out, ev ? mem[m_pc[7:2]] : 32'h0);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("halted", 32'(halted), 32'(m_halt));
    chk("retired_cnt", retired_cnt, perf(m_ret));
    chk("stall_cnt", stall_cnt, perf(m_stc));
  endtask

  task automatic advance();
    logic [31:0] seq, tgt;
    bit bad;
    @(posedge clk);
    bad = (m_pc >= 32'd256) || (m_pc[1:0] != 2'b00);
    if (m_boot) m_boot = 0;
    else if (m_halt) begin end
    else if (m_stall) begin
      m_stc = m_stc + 32'd1;
      if (!stall) m_stall = 0;
    end else if (bad) m_halt = 1;
    else if (stall) m_stall = 1;
    else begin
      m_ret = m_ret + 32'd1;
      seq = m_pc + 32'd4;
      if (jump) tgt = {seq[31:28], jump_index, 2'b00};
      else if (branch_taken) tgt = seq + branch_offset * 32'd4;
      else tgt = seq;
      if (jump && tgt == m_pc) m_halt = 1;
      m_pc = tgt;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst address", address, 32'h0);
    chk("rst valid", 32'(valid), 32'h0);
    chk("rst halted", 32'(halted), 32'h0);
    chk("rst instr_out", instr_out, 32'h0);
    chk("rst retired_cnt", retired_cnt, 32'h0);
    chk("rst stall_cnt", stall_cnt, 32'h0);
    m_pc = 32'h0; m_ret = 32'h0; m_stc = 32'h0;
    m_boot = 1; m_stall = 0; m_halt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    #1;
    check_model();
    advance();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    vt[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 26'd0,  32'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 26'd0,  32'h00, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 26'd8,  32'h04, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 32'd2,         1'b1, 26'd9,  32'h20, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 26'd0,  32'h24, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 26'd0,  32'h1C, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 32'd2,         1'b0, 26'd0,  32'h20, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 26'd3,  32'h2C, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 32'd5,         1'b0, 26'd0,  32'h2C, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 26'd0,  32'h2C, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 26'd0,  32'h2C, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 26'd14, 32'h30, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 26'd14, 32'h38, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b1, 32'd1,         1'b0, 26'd0,  32'h38, 1'b0, 1'b1};
    vt[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 26'd2,  32'h38, 1'b0, 1'b1};

    @(negedge clk);
    do_reset();

    // directed table: boot, priority, branch arithmetic, stall, self-jump halt
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].s, vt[i].br, vt[i].off, vt[i].j, vt[i].idx);
      #1;
      chk($sformatf("vec%0d address", i), address, vt[i].ea);
      chk($sformatf("vec%0d valid", i), 32'(valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d halted", i), 32'(halted), 32'(vt[i].eh));
      check_model();
      advance();
    end

    // reset while halted
    #2;
    do_reset();

    // jump to last word, step past end of memory
    idle_step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 26'd63);
    #1; check_model(); advance();
    idle_step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    #1;
    chk("oob address", address, 32'h100);
    chk("oob valid", 32'(valid), 32'h0);
    chk("oob halted", 32'(halted), 32'h0);
    check_model(); advance();
    #1;
    chk("oob halt address", address, 32'h100);
    chk("oob halt flag", 32'(halted), 32'h1);
    check_model(); advance();
    idle_step();

    // counters: 10 retirements then 3 stall cycles
    do_reset();
    for (int i = 0; i < 11; i++) idle_step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'd3, 1'b0, 26'h0);
      #1; check_model(); advance();
    end
    idle_step();
    #1;
    chk("perf retired", retired_cnt, perf(32'd10));
    chk("perf stall", stall_cnt, perf(32'd3));
    chk("perf resume address", address, 32'h28);

    // randomized run
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 400) == 0) do_reset();
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
            32'($urandom_range(0, 16)) - 32'd8, $urandom_range(0, 9) == 0,
            26'($urandom_range(0, 70)));
      #1;
      check_model();
      advance();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
